// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed active-low 7-seg bus,
// debounces each digit and reassembles a BCD frame.
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  err,
  output logic                  valid
);

  localparam int W = DIGITS + 7;
  localparam logic [3:0] STB = 4'(STABLE);

  typedef enum logic [1:0] {
    SAMPLE,
    ACCEPT,
    EMIT
  } state_t;

  state_t                state;
  logic [W-1:0]          cur;
  logic [W-1:0]          r_in;
  logic [3:0]            cnt;
  logic                  acc_done;
  logic [DIGITS-1:0]     seen;
  logic [4*DIGITS-1:0]   stage;
  logic [DIGITS-1:0]     stage_blank;
  logic                  stage_err;
  logic [DIGITS-1:0]     sel;
  logic                  same;
  logic                  accept;
  logic                  full;
  logic [3:0]            nib;
  logic                  blank;
  logic                  bad;

  assign cur    = {an, seg};
  assign same   = (cur == r_in);
  assign sel    = ~an;
  assign full   = &seen;
  assign accept = same && $onehot(sel) && !acc_done
                  && (cnt >= STB - 4'd1);
  assign valid  = (state == EMIT);

  always_comb begin
    nib   = 4'hE;
    blank = 1'b0;
    bad   = 1'b0;
    unique case (seg)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b1111111: begin
        nib   = 4'hF;
        blank = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SAMPLE;
      r_in        <= '0;
      cnt         <= '0;
      acc_done    <= 1'b0;
      seen        <= '0;
      stage       <= '0;
      stage_blank <= '0;
      stage_err   <= 1'b0;
      bcd_out     <= '0;
      blank_mask  <= '0;
      err         <= 1'b0;
    end else begin
      r_in <= cur;
      if (same) begin
        if (cnt != STB) cnt <= cnt + 4'd1;
      end else begin
        cnt      <= '0;
        acc_done <= 1'b0;
      end
      if (accept) begin
        acc_done <= 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            stage[4*i +: 4] <= nib;
            stage_blank[i]  <= blank;
          end
        end
      end
      // Publishing reads the old staging; a same-edge accept opens the next frame.
      if (full) begin
        bcd_out    <= stage;
        blank_mask <= stage_blank;
        err        <= stage_err;
        seen       <= accept ? sel : '0;
        stage_err  <= accept & bad;
      end else if (accept) begin
        seen <= seen | sel;
        if (bad) stage_err <= 1'b1;
      end
      if (full)        state <= EMIT;
      else if (accept) state <= ACCEPT;
      else             state <= SAMPLE;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scenarios for the 7-seg scan reader,
// DIGITS=4, STABLE=3.
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd_out;
  logic [3:0]  blank_mask;
  logic        err;
  logic        valid;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;
  int vcnt   = 0;
  int vedge  = 0;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .seg(seg),
    .bcd_out(bcd_out),
    .blank_mask(blank_mask),
    .err(err),
    .valid(valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt++;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      vcnt++;
      vedge = ecnt;
    end
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic hold(input logic [3:0] a, input logic [6:0] s,
                      input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    #12;
    checks++;
    if (bcd_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_bcd got=%h want=0000", bcd_out);
    end
    checks++;
    if (blank_mask !== 4'h0 || err !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b/%b/%b want=0000/0/0",
               blank_mask, err, valid);
    end
    #5 rst = 1'b0;
    idle(3);
  endtask

  task automatic test_basic;
    int v0;
    v0 = vcnt;
    hold(an_of(0), seg_of(1), 6);
    hold(an_of(1), seg_of(2), 6);
    hold(an_of(2), seg_of(3), 6);
    hold(an_of(3), seg_of(4), 6);
    idle(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL basic_pulses got=%0d want=1", vcnt - v0);
    end
    checks++;
    if (bcd_out !== 16'h4321) begin
      errors++;
      $display("FAIL basic_bcd got=%h want=4321", bcd_out);
    end
    checks++;
    if (blank_mask !== 4'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got=%b/%b want=0000/0",
               blank_mask, err);
    end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcnt;
    hold(an_of(0), seg_of(5), 2);
    hold(an_of(1), seg_of(6), 6);
    hold(an_of(2), seg_of(7), 6);
    hold(an_of(3), seg_of(8), 6);
    idle(4);
    checks++;
    if (vcnt !== v0) begin
      errors++;
      $display("FAIL glitch_no_valid got=%0d want=0", vcnt - v0);
    end
    hold(an_of(0), seg_of(5), 4);
    idle(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL glitch_pulses got=%0d want=1", vcnt - v0);
    end
    checks++;
    if (bcd_out !== 16'h8765) begin
      errors++;
      $display("FAIL glitch_bcd got=%h want=8765", bcd_out);
    end
  endtask

  task automatic test_blank_err;
    hold(an_of(0), seg_of(0), 6);
    hold(an_of(1), seg_of(8), 6);
    hold(an_of(2), 7'b1111111, 6);
    hold(an_of(3), 7'b1010101, 6);
    idle(4);
    checks++;
    if (bcd_out !== 16'hEF80) begin
      errors++;
      $display("FAIL blank_bcd got=%h want=ef80", bcd_out);
    end
    checks++;
    if (blank_mask !== 4'b0100) begin
      errors++;
      $display("FAIL blank_mask got=%b want=0100", blank_mask);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL blank_err got=%b want=1", err);
    end
    for (int d = 0; d < 4; d++) hold(an_of(d), seg_of(9), 6);
    idle(4);
    checks++;
    if (bcd_out !== 16'h9999) begin
      errors++;
      $display("FAIL clean_bcd got=%h want=9999", bcd_out);
    end
    checks++;
    if (err !== 1'b0 || blank_mask !== 4'h0) begin
      errors++;
      $display("FAIL clean_flags got=%b/%b want=0/0000",
               err, blank_mask);
    end
  endtask

  task automatic test_invalid_an;
    int v0;
    v0 = vcnt;
    hold(an_of(0), seg_of(1), 6);
    hold(an_of(1), seg_of(4), 6);
    hold(4'b1111, seg_of(8), 10);
    hold(4'b1100, 7'b1010101, 10);
    checks++;
    if (vcnt !== v0 || err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_an got=%0d/%b want=0/0", vcnt - v0, err);
    end
    hold(an_of(2), seg_of(1), 6);
    hold(an_of(3), seg_of(5), 6);
    idle(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL invalid_pulses got=%0d want=1", vcnt - v0);
    end
    checks++;
    if (bcd_out !== 16'h5141 || err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_bcd got=%h/%b want=5141/0", bcd_out, err);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcnt;
    hold(an_of(0), seg_of(2), 6);
    hold(an_of(1), seg_of(2), 6);
    hold(an_of(2), seg_of(2), 6);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bcd_out !== 16'h0 || err !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out got=%h/%b/%b want=0000/0/0",
               bcd_out, err, valid);
    end
    #2 rst = 1'b0;
    hold(an_of(3), seg_of(3), 6);
    idle(6);
    checks++;
    if (vcnt !== v0) begin
      errors++;
      $display("FAIL midrst_no_valid got=%0d want=0", vcnt - v0);
    end
    hold(an_of(0), seg_of(6), 6);
    hold(an_of(1), seg_of(0), 6);
    hold(an_of(2), seg_of(9), 6);
    hold(an_of(3), seg_of(3), 6);
    idle(4);
    checks++;
    if (vcnt - v0 !== 1 || bcd_out !== 16'h3906) begin
      errors++;
      $display("FAIL midrst_frame got=%0d/%h want=1/3906",
               vcnt - v0, bcd_out);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    int e0;
    v0 = vcnt;
    hold(an_of(3), seg_of(2), 6);
    hold(an_of(3), seg_of(7), 6);
    hold(an_of(0), seg_of(0), 6);
    hold(an_of(1), seg_of(1), 6);
    @(negedge clk);
    an  = an_of(2);
    seg = seg_of(9);
    e0  = ecnt + 1;
    repeat (6) @(posedge clk);
    idle(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL latency_pulses got=%0d want=1", vcnt - v0);
    end
    checks++;
    if (vedge !== e0 + STABLE + 1) begin
      errors++;
      $display("FAIL latency_edge got=%0d want=%0d",
               vedge - e0, STABLE + 1);
    end
    checks++;
    if (bcd_out !== 16'h7910) begin
      errors++;
      $display("FAIL repeat_bcd got=%h want=7910", bcd_out);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_blank_err;
    test_invalid_an;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
